uart_tx_responder: RTL and testbench
====================================

UART_TX_RESPONDER -- requirements
Module: uart_tx_responder

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'hFF20_0100, the 8-byte-aligned base of the register window.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434, the clock cycles per serial bit (≥2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, the TX FIFO entries (power of two, 2..16).
REQ-004 SHALL have port clock, input, 1 bit; single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-006 SHALL have port bus_address, input, 32 bits; byte address from the core.
REQ-007 SHALL have port bus_write_data, input, 32 bits; store data.
REQ-008 SHALL have port bus_format, input, 3 bits; funct3 access format.
REQ-009 SHALL have port bus_read_enable, input, 1 bit; load strobe.
REQ-010 SHALL have port bus_write_enable, input, 1 bit; store strobe.
REQ-011 SHALL have port bus_data_fetched, output, 32 bits; read data, zero when not selected.
REQ-012 SHALL have port uart_tx, output, 1 bit; serial line, idle high.
REQ-013 SHALL have port tx_empty_irq, output, 1 bit; high while the FIFO is empty and the serializer is idle.

Function
REQ-014 SHALL select when bus_address[31:3] == BASE_ADDRESS[31:3]; offset 0x0 is DATA, offset 0x4 is STATUS; bus_address[1:0] is ignored.
REQ-015 SHALL drive bus_data_fetched combinationally from registered state when selected and bus_read_enable=1, otherwise 32'h0.
REQ-016 SHALL return 0 on a DATA read; SHALL return STATUS = {24'b0, count[3:0], overflow, busy, empty, full} (bits 7:4, 3, 2, 1, 0).
REQ-017 SHALL push bus_write_data[7:0] into the FIFO at the rising edge where bus_write_enable=1 and DATA is selected, for any bus_format.
REQ-018 SHALL judge full/empty on pre-edge state; a DATA write while full is dropped, the FIFO is unchanged, and overflow is set to 1 (sticky), even if a pop occurs in the same cycle.
REQ-019 SHALL clear overflow when STATUS is written with bus_write_data[3]=1; other STATUS bits are read-only.
REQ-020 SHALL handle FIFO pointers modulo FIFO_DEPTH with wrap-around; count ranges 0..FIFO_DEPTH.
REQ-021 SHALL implement the serializer FSM IDLE -> START -> DATA -> STOP -> IDLE (PARITY between DATA and STOP when REQ-029 is active).
REQ-022 SHALL, in IDLE, with the FIFO non-empty at an edge, pop the head byte into the shift register and enter START; uart_tx goes low one cycle after the edge that pushed into an empty FIFO.
REQ-023 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a down-counter reloaded on every bit transition.
REQ-024 SHALL send DATA LSB first, 8 bits, tracked by a 3-bit bit index that wraps 7 -> leave DATA.
REQ-025 SHALL drive STOP high for CLKS_PER_BIT cycles; then go to IDLE, or go directly to START with the next byte popped if the FIFO is non-empty, giving no idle gap.
REQ-026 SHALL register uart_tx (glitch-free output); busy = (state != IDLE).

Reset
REQ-027 SHALL, with reset=1 at an edge, set state=IDLE, FIFO pointers/count=0, overflow=0, bit counter=0, uart_tx=1; tx_empty_irq is then 1 and bus_data_fetched is 0.
REQ-028 SHALL, on reset mid-frame, abort the frame and discard FIFO contents; uart_tx is high one cycle after the reset edge; reset has priority over a simultaneous bus write.

Configuration
REQ-029 SHALL, when macro UART_TX_PARITY_EN is defined, insert a PARITY state after DATA sending the even parity (XOR of 8 data bits), for an 11-bit frame; when undefined, the frame is 10 bits and no PARITY state exists.

Verification
REQ-030 SHALL cover, with CLKS_PER_BIT=4: reset, then write DATA 0x55 -> uart_tx low 1 cycle later, bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high; 40 cycles total (44 with UART_TX_PARITY_EN, parity 0).
REQ-031 SHALL cover: 9 back-to-back DATA writes 0x01..0x09 with depth 8 -> 0x01 starts at once; 0x02..0x09 fill the FIFO (full=1, count=8); a 10th write 0x0A sets overflow=1 and is never transmitted.
REQ-032 SHALL cover: STATUS read after REQ-031 -> 32'h0000_008D; a STATUS write of 0x8 then a read -> overflow=0.
REQ-033 SHALL cover: two bytes 0xA5, 0x3C queued -> frames contiguous, with no idle cycle between the STOP of 0xA5 and the START of 0x3C; tx_empty_irq rises after the final STOP.
REQ-034 SHALL cover: reset asserted mid-DATA of 0xFF with 3 bytes queued -> uart_tx=1, count=0, empty=1 next cycle; nothing further is transmitted.
REQ-035 SHALL cover: a read at BASE_ADDRESS+8 or a write at BASE_ADDRESS-4 -> bus_data_fetched=0, no FIFO change.

Source files
------------

// File: rtl/uart_tx_responder.sv
// uart_tx_responder: memory-mapped UART transmitter with a TX FIFO and an 8N1 serializer.
// Ports: clock/reset (sync, active-high); bus_address, bus_write_data, bus_format,
// bus_read_enable, bus_write_enable from the core; bus_data_fetched read data (0 when
// not selected); uart_tx serial line (idle high); tx_empty_irq (FIFO empty and idle).
// Registers: DATA at offset 0x0 (write pushes a byte, reads 0), STATUS at offset 0x4
// = {count[3:0], overflow, busy, empty, full}; writing STATUS bit 3 clears overflow.
// Option: define UART_TX_PARITY_EN to append an even parity bit (11-bit frame).
module uart_tx_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'hFF20_0100,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [2:0]  bus_format,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_data_fetched,
    output logic        uart_tx,
    output logic        tx_empty_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic parity;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count;
    logic          overflow;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          sel, data_wr, stat_wr, full, empty, busy, bit_done, push, pop;
    logic [31:0]   status;
    logic          unused_bits;

    assign sel      = bus_address[31:3] == BASE_ADDRESS[31:3];
    assign data_wr  = sel & ~bus_address[2] & bus_write_enable;
    assign stat_wr  = sel & bus_address[2] & bus_write_enable;
    assign full     = count == 5'(FIFO_DEPTH);
    assign empty    = count == 5'd0;
    assign busy     = state != IDLE;
    assign bit_done = bit_cnt == '0;
    assign push     = data_wr & ~full;
    // Pop when idle, or at the last STOP cycle so the next frame follows with no gap.
    assign pop      = ~empty & (state == IDLE | (state == STOP & bit_done));
    assign status   = {24'b0, count[3:0], overflow, busy, empty, full};
    assign bus_data_fetched = (sel & bus_read_enable & bus_address[2]) ? status : 32'h0;
    assign tx_empty_irq = empty & ~busy;
    assign unused_bits  = ^{bus_format, bus_address[1:0], bus_write_data[31:8]};

    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= bus_write_data[7:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + 5'(push) - 5'(pop);
            if (data_wr & full) overflow <= 1'b1;
            else if (stat_wr & bus_write_data[3]) overflow <= 1'b0;
            if (pop) begin
                state   <= START;
                shreg   <= mem[rd_ptr];
                bit_cnt <= RELOAD;
                bit_idx <= '0;
                uart_tx <= 1'b0;
`ifdef UART_TX_PARITY_EN
                parity  <= ^mem[rd_ptr];
`endif
            end else if (busy) begin
                if (!bit_done) bit_cnt <= bit_cnt - CW'(1);
                else begin
                    bit_cnt <= RELOAD;
                    case (state)
                        START: begin
                            state   <= DATA;
                            uart_tx <= shreg[0];
                        end
                        DATA: begin
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state   <= PARITY;
                                uart_tx <= parity;
`else
                                state   <= STOP;
                                uart_tx <= 1'b1;
`endif
                            end else begin
                                shreg   <= shreg >> 1;
                                uart_tx <= shreg[1];
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        PARITY: begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end
`endif
                        default: begin
                            state   <= IDLE;
                            uart_tx <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_responder.sv
// tb_uart_tx_responder: directed, self-checking bench for uart_tx_responder.
module tb_uart_tx_responder;
    localparam logic [31:0] BASE = 32'hFF20_0100;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] bus_address = '0;
    logic [31:0] bus_write_data = '0;
    logic [2:0]  bus_format = 3'b010;
    logic        bus_read_enable = 1'b0;
    logic        bus_write_enable = 1'b0;
    logic [31:0] bus_data_fetched;
    logic        uart_tx;
    logic        tx_empty_irq;

    uart_tx_responder #(.BASE_ADDRESS(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clock(clock),
        .reset(reset),
        .bus_address(bus_address),
        .bus_write_data(bus_write_data),
        .bus_format(bus_format),
        .bus_read_enable(bus_read_enable),
        .bus_write_enable(bus_write_enable),
        .bus_data_fetched(bus_data_fetched),
        .uart_tx(uart_tx),
        .tx_empty_irq(tx_empty_irq)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    logic [7:0] rx_q[$];
    bit         rx_ok[$];
    int         rx_t[$];

    initial forever begin
        @(posedge clock);
        cyc_no++;
    end

    // Serial receiver: every cycle of each bit must hold the same level.
    initial begin
        logic [FL-1:0] v;
        bit ok, ab;
        int t0;
        forever begin
            @(negedge clock);
            if (!reset && uart_tx === 1'b0) begin
                t0 = cyc_no;
                ok = 1;
                ab = 0;
                v = '0;
                for (int k = 0; k < FL && !ab; k++)
                    for (int p = 0; p < CPB && !ab; p++) begin
                        if (k != 0 || p != 0) @(negedge clock);
                        if (reset) ab = 1;
                        else if (p == 0) v[k] = uart_tx;
                        else if (uart_tx !== v[k]) ok = 0;
                    end
                if (!ab) begin
                    if (v[0] || !v[FL-1]) ok = 0;
`ifdef UART_TX_PARITY_EN
                    if (v[9] != ^v[8:1]) ok = 0;
`endif
                    rx_q.push_back(v[8:1]);
                    rx_ok.push_back(ok);
                    rx_t.push_back(t0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [31:0] exp_rd;
        logic [31:0] exp_st;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_status(input string n, input logic [31:0] e);
        bus_address = BASE + 32'd4;
        bus_read_enable = 1'b1;
        #1;
        chk(n, bus_data_fetched, e);
        bus_read_enable = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_address = a;
        bus_write_data = d;
        bus_write_enable = 1'b1;
        cyc();
        bus_write_enable = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        rx_q.delete();
        rx_ok.delete();
        rx_t.delete();
    endtask

    task automatic wait_idle(input string n, input int budget);
        int k = 0;
        while (!tx_empty_irq && k < budget) begin
            cyc();
            k++;
        end
        chk(n, 32'(tx_empty_irq), 32'd1);
    endtask

    task automatic chk_rx(input string n, input int i, input logic [7:0] e);
        if (i < rx_q.size()) chk(n, {23'b0, rx_ok[i], rx_q[i]}, {23'b0, 1'b1, e});
        else begin
            checks++;
            errors++;
            $display("FAIL %s frame %0d missing, expected byte %h", n, i, e);
        end
    endtask

    initial begin
        vecs[0] = '{BASE + 32'd4, 32'h0,  1'b0, 1'b1, 32'h02, 32'h02};
        vecs[1] = '{BASE + 32'd7, 32'h0,  1'b0, 1'b1, 32'h02, 32'h02};
        vecs[2] = '{BASE,         32'h0,  1'b0, 1'b1, 32'h00, 32'h02};
        vecs[3] = '{BASE + 32'd8, 32'h0,  1'b0, 1'b1, 32'h00, 32'h02};
        vecs[4] = '{BASE - 32'd4, 32'h5A, 1'b1, 1'b0, 32'h00, 32'h02};
        vecs[5] = '{BASE + 32'd8, 32'h5A, 1'b1, 1'b1, 32'h00, 32'h02};
        vecs[6] = '{BASE + 32'd4, 32'hFF, 1'b1, 1'b0, 32'h00, 32'h02};
        vecs[7] = '{BASE + 32'd4, 32'h0,  1'b0, 1'b0, 32'h00, 32'h02};
        vecs[8] = '{32'h0020_0104, 32'h0, 1'b0, 1'b1, 32'h00, 32'h02};

        do_reset();
        chk("reset_tx", 32'(uart_tx), 32'd1);
        chk("reset_irq", 32'(tx_empty_irq), 32'd1);
        chk("reset_rd_idle", bus_data_fetched, 32'h0);
        chk_status("reset_status", 32'h02);

        for (int i = 0; i < 9; i++) begin
            bus_address = vecs[i].addr;
            bus_write_data = vecs[i].wdata;
            bus_write_enable = vecs[i].we;
            bus_read_enable = vecs[i].re;
            #1;
            chk($sformatf("vec%0d_rd", i), bus_data_fetched, vecs[i].exp_rd);
            cyc();
            bus_write_enable = 1'b0;
            bus_read_enable = 1'b0;
            chk_status($sformatf("vec%0d_status", i), vecs[i].exp_st);
        end
        repeat (3) cyc();
        chk("table_no_tx", 32'(uart_tx), 32'd1);
        chk("table_no_frame", 32'(rx_q.size()), 32'd0);

        // Single 0x55 frame with exact timing.
        do_reset();
        wr(BASE, 32'h55);
        chk("push_tx_still_high", 32'(uart_tx), 32'd1);
        chk("push_irq_low", 32'(tx_empty_irq), 32'd0);
        chk_status("push_status", 32'h10);
        cyc();
        chk("start_low", 32'(uart_tx), 32'd0);
        chk_status("start_status", 32'h06);
        repeat (FL * CPB - 1) cyc();
        chk("last_stop_high", 32'(uart_tx), 32'd1);
        chk("last_stop_irq", 32'(tx_empty_irq), 32'd0);
        cyc();
        chk("frame_end_irq", 32'(tx_empty_irq), 32'd1);
        chk_status("frame_end_status", 32'h02);
        chk("frame55_count", 32'(rx_q.size()), 32'd1);
        chk_rx("frame55", 0, 8'h55);

        // Burst of 9 into depth-8 FIFO, then overflow and clear.
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            bus_address = BASE;
            bus_write_data = 32'(i);
            bus_write_enable = 1'b1;
            cyc();
        end
        bus_write_enable = 1'b0;
        chk_status("fifo_full", 32'h85);
        wr(BASE, 32'h0A);
        chk_status("overflow_set", 32'h8D);
        wr(BASE + 32'd4, 32'h8);
        chk_status("overflow_clear", 32'h85);
        wait_idle("burst_idle", 1000);
        chk("burst_count", 32'(rx_q.size()), 32'd9);
        for (int i = 0; i < 9; i++) chk_rx($sformatf("burst%0d", i), i, 8'(i + 1));
        for (int i = 1; i < 9 && i < rx_t.size(); i++)
            chk($sformatf("burst_gap%0d", i), 32'(rx_t[i] - rx_t[i-1]), 32'(FL * CPB));

        // Two queued bytes: contiguous frames, irq right after final stop.
        do_reset();
        wr(BASE, 32'hA5);
        wr(BASE, 32'h3C);
        wait_idle("pair_idle", 300);
        chk("pair_count", 32'(rx_q.size()), 32'd2);
        chk_rx("pair_a5", 0, 8'hA5);
        chk_rx("pair_3c", 1, 8'h3C);
        if (rx_t.size() == 2) begin
            chk("pair_gap", 32'(rx_t[1] - rx_t[0]), 32'(FL * CPB));
            chk("pair_irq_time", 32'(cyc_no - rx_t[0]), 32'(2 * FL * CPB));
        end

        // Reset mid-DATA of 0xFF with 3 bytes queued, concurrent write ignored.
        do_reset();
        wr(BASE, 32'hFF);
        wr(BASE, 32'h11);
        wr(BASE, 32'h22);
        wr(BASE, 32'h33);
        repeat (14) cyc();
        chk("mid_data_tx", 32'(uart_tx), 32'd1);
        chk_status("mid_data_status", 32'h34);
        reset = 1'b1;
        bus_address = BASE;
        bus_write_data = 32'h77;
        bus_write_enable = 1'b1;
        cyc();
        reset = 1'b0;
        bus_write_enable = 1'b0;
        chk("abort_tx", 32'(uart_tx), 32'd1);
        chk("abort_irq", 32'(tx_empty_irq), 32'd1);
        chk_status("abort_status", 32'h02);
        begin
            bit any_low = 0;
            repeat (200) begin
                cyc();
                if (uart_tx !== 1'b1) any_low = 1;
            end
            chk("abort_quiet", 32'(any_low), 32'd0);
        end
        chk("abort_no_frame", 32'(rx_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
